// File: rtl/writeback_queue.sv
// writeback_queue
//   Buffers register-file write-backs and drains at most one per cycle into
//   the register file's general write port (address_3) or its stack write
//   port (register 0). Queued writes that are not yet in the register file
//   are forwarded, youngest first, to the two read addresses.
//
// Optional feature macro: WRITEBACK_QUEUE_FORWARD_EN
//   defined   -> forwarding compare logic is built
//   undefined -> forward_hit_* and forward_data_* are tied to 0; the consumer
//                must hold reads until occupancy is 0
//
// Ports
//   clk, reset_n                    clock, synchronous active-low reset
//   enq_valid/enq_ready             producer handshake (ready = not full)
//   enq_is_stack/enq_address/enq_data  write-back payload
//   drain_stall                     register file port unavailable, head held
//   general_register_write_enable, address_3, general_register_write_data
//                                   general write port (head entry)
//   stack_write_enable, stack_register_write_data
//                                   stack write port (head entry)
//   address_1/2, forward_hit_1/2, forward_data_1/2
//                                   read-address forwarding
//   occupancy                       number of queued entries
module writeback_queue #(
  parameter int ADDR_WIDTH_RF = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic                     enq_is_stack,
  input  logic [ADDR_WIDTH_RF-1:0] enq_address,
  input  logic [DATA_WIDTH-1:0]    enq_data,
  input  logic                     drain_stall,
  output logic                     general_register_write_enable,
  output logic [ADDR_WIDTH_RF-1:0] address_3,
  output logic [DATA_WIDTH-1:0]    general_register_write_data,
  output logic                     stack_write_enable,
  output logic [DATA_WIDTH-1:0]    stack_register_write_data,
  input  logic [ADDR_WIDTH_RF-1:0] address_1,
  input  logic [ADDR_WIDTH_RF-1:0] address_2,
  output logic                     forward_hit_1,
  output logic                     forward_hit_2,
  output logic [DATA_WIDTH-1:0]    forward_data_1,
  output logic [DATA_WIDTH-1:0]    forward_data_2,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                     is_stack;
    logic [ADDR_WIDTH_RF-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_entry_t;

  wb_entry_t [DEPTH-1:0] entry_q, entry_d;
  logic      [DEPTH-1:0] valid_q, valid_d;
  logic      [PTR_W-1:0] head_q, head_d;
  logic      [PTR_W-1:0] tail_q, tail_d;
  logic      [CNT_W-1:0] count_q, count_d;

  logic      full, empty, enq_fire, deq_fire, head_vld;
  wb_entry_t head_entry;

  // Queue control and next state
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    // No pass-through when full: ready ignores a same-cycle dequeue.
    enq_fire = enq_valid && !full;
    deq_fire = !empty && !drain_stall;

    entry_d = entry_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // Head and tail only coincide when empty or full, and then only one of
    // the two fires, so the update order below is safe.
    if (deq_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (enq_fire) begin
      entry_d[tail_q].is_stack = enq_is_stack;
      entry_d[tail_q].addr     = enq_is_stack ? '0 : enq_address;
      entry_d[tail_q].data     = enq_data;
      valid_d[tail_q]          = 1'b1;
      tail_d                   = tail_q + 1'b1;
    end

    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      entry_q <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write ports, straight from the head entry
  always_comb begin
    head_entry = entry_q[head_q];
    head_vld   = valid_q[head_q];

    enq_ready = !full;
    occupancy = count_q;

    general_register_write_enable = head_vld && !drain_stall && !head_entry.is_stack;
    stack_write_enable            = head_vld && !drain_stall &&  head_entry.is_stack;

    address_3                   = head_vld ? head_entry.addr : '0;
    general_register_write_data = head_vld ? head_entry.data : '0;
    stack_register_write_data   = head_vld ? head_entry.data : '0;
  end

`ifdef WRITEBACK_QUEUE_FORWARD_EN
  // Walk from head (oldest) to tail (youngest); a later match overrides an
  // earlier one so the youngest pending value wins. The head still matches
  // while being drained because the register file only updates at the edge,
  // and this cycle's enqueue is not yet in entry_q.
  logic [PTR_W-1:0] fwd_idx;

  always_comb begin
    forward_hit_1  = 1'b0;
    forward_hit_2  = 1'b0;
    forward_data_1 = '0;
    forward_data_2 = '0;
    fwd_idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && valid_q[fwd_idx]) begin
        if (entry_q[fwd_idx].addr == address_1) begin
          forward_hit_1  = 1'b1;
          forward_data_1 = entry_q[fwd_idx].data;
        end
        if (entry_q[fwd_idx].addr == address_2) begin
          forward_hit_2  = 1'b1;
          forward_data_2 = entry_q[fwd_idx].data;
        end
      end
    end
  end
`else
  // Read addresses are unused without forwarding.
  logic unused_read_addr;
  assign unused_read_addr = ^{address_1, address_2};

  assign forward_hit_1  = 1'b0;
  assign forward_hit_2  = 1'b0;
  assign forward_data_1 = '0;
  assign forward_data_2 = '0;
`endif

endmodule
